shift_mul_seq: RTL and testbench
================================

# shift_mul_seq

Iterative signed fixed-point multiplier for the STDP math datapath. It sits directly around the 32-bit barrel shifter: each cycle it feeds the shifter an operand, a shift op and an amount, then consumes the shifted result into a magnitude accumulator. It replaces a hard multiplier in weight-update paths, trading 32 cycles of latency for area. Inputs and outputs use ready/valid handshakes.

## Interface
- FRAC, 16, fractional bits of the Q format for a, b and the result; legal range 0..31.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  32  signed multiplicand (Q(31-FRAC).FRAC).
- b  in  32  signed multiplier (same format).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  signed product (same format).
- ovf  out  1  product magnitude overflowed 32-bit signed range; qualified by out_valid.
- sh_in  out  32  shifter data input.
- sh_op  out  2  shifter op: 00 SHL, 01 SHR, 10 ASR, 11 ROR (ROR is never issued).
- sh_s  out  5  shifter amount.
- sh_res  in  32  shifter output; combinational return within the same cycle.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. An edge with in_valid=1 latches |a| (unsigned 32-bit; |0x80000000| = 0x80000000), b, sign = a[31]^b[31], |b|, lzc(|a|), and clears acc (33-bit), ovf and i. Next state RUN.
- RUN, i = 0..31, one step per cycle:
  - k = i - FRAC. If k >= 0: sh_op=SHL, sh_s=k. Else sh_op=SHR, sh_s=-k.
  - sh_in = |a|.
  - If |b|[i]=1: acc += sh_res; ovf is set if the SHL loses set bits (k > lzc(|a|)) or acc[32:31] becomes nonzero. If |b|[i]=0, acc is unchanged (shifter still driven).
  - Each partial product is truncated toward zero (floor of magnitude).
  - After i=31, go to DONE.
- DONE: out_valid=1; result = sign ? -mag : mag, where mag is set by the Configuration section. It holds until an edge with out_ready=1, then goes to IDLE.
- Outside RUN: sh_in, sh_op and sh_s are driven to 0.
- A sign of 0 is produced when the magnitude is 0. No negative zero is possible.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, result=0, ovf=0, sh_in=0, sh_op=0, sh_s=0. The internal accumulator and counter are cleared.
- Latency: operands accepted at edge N; out_valid rises after edge N+32; result is visible in cycle N+33.
- Throughput: at most one operation per 34 cycles. in_ready is low during RUN and DONE. There is no input accept in the same cycle as output release. IDLE is entered on the release edge.
- out_valid stays high, and result and ovf stay stable, while out_ready=0.
- rst_n low during RUN or DONE aborts the operation immediately. No out_valid is produced, and the block returns to IDLE with reset values.
- The sh_res path is combinational into acc. The shifter plus the 33-bit add must close in one clk period.

## Configuration
- SHIFT_MUL_SAT_EN defined: if ovf=1, mag saturates so that result = 0x7FFFFFFF (positive) or 0x80000000 (negative).
- Not defined: mag = acc[31:0], wrapping modulo 2^32 before negation. ovf is still reported.

## Structure
- Shared package shift_pkg holds the op-code constants SH_SHL=2'b00, SH_SHR=2'b01, SH_ASR=2'b10 and SH_ROR=2'b11, plus the state enum {IDLE, RUN, DONE}. The barrel shifter and this block both use it.
- One sub-module, shift_mul_lzc: a combinational 32-bit leading-zero count with a 6-bit output, where 32 means the input is zero.
- The barrel shifter is instantiated by the parent, not inside this block.

## Test plan
All scenarios use FRAC=16.
- a=0x00018000 (1.5), b=0x00020000 (2.0) -> result=0x00030000 and ovf=0. out_valid is high exactly 33 cycles after the accept edge.
- a=0xFFFE8000 (-1.5), b=0x00020000 -> result=0xFFFD0000 and ovf=0. a=0, b=0x80000000 -> result=0 and ovf=0.
- a=0x7FFF0000, b=0x00020000 -> ovf=1. With SHIFT_MUL_SAT_EN, result=0x7FFFFFFF; without it, result=0xFFFE0000.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Result stays stable and in_ready=0 throughout. When out_ready=1, there is one handshake and then in_ready=1.
- Reset mid-RUN at i=12: all outputs go to reset values asynchronously, no spurious out_valid appears, and a following 1.0 × 1.0 operation returns 0x00010000.
- Shifter drive check for b=0x00010001: sh_op=SHR with sh_s=16 at i=0, sh_op=SHL with sh_s=0 at i=16, and sh_op/sh_s/sh_in are 0 in IDLE and DONE.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the barrel shifter and the shift-based sequential multiplier.
//  - SH_* : shifter op-codes driven on sh_op
//  - state_e : control states of shift_mul_seq
package shift_pkg;

  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_mul_lzc.sv
// 32-bit leading-zero counter (combinational).
//  i_data  : value to examine
//  o_count : number of leading zeros, 0..32 (32 means i_data == 0)
module shift_mul_lzc (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  // Scan from LSB to MSB so the highest set bit is the last one to write.
  always_comb begin
    o_count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/shift_mul_seq.sv
// Iterative signed fixed-point multiplier built around an external 32-bit barrel shifter.
// One partial product per cycle over 32 cycles; ready/valid on both sides.
// Ports:
//  clk, rst_n            : clock, asynchronous active-low reset
//  in_valid/in_ready/a/b : operand handshake, signed Q(31-FRAC).FRAC operands
//  out_valid/out_ready   : result handshake
//  result, ovf           : signed product and overflow flag (qualified by out_valid)
//  sh_in/sh_op/sh_s      : request to the external shifter (zero outside RUN)
//  sh_res                : shifter output, combinational return in the same cycle
// Build option: define SHIFT_MUL_SAT_EN to saturate the result on overflow; otherwise the
// magnitude wraps modulo 2^32 before sign is applied.
module shift_mul_seq
  import shift_pkg::*;
#(
  parameter int unsigned FRAC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic [31:0] sh_in,
  output logic [1:0]  sh_op,
  output logic [4:0]  sh_s,
  input  logic [31:0] sh_res
);

  localparam logic signed [6:0] FracS = 7'(FRAC);

  state_e      r_state, w_state_d;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic        r_sign;
  logic [5:0]  r_lzc;
  logic [32:0] r_acc;
  logic        r_ovf;
  logic [4:0]  r_i;

  logic [31:0]       w_abs_a;
  logic [31:0]       w_abs_b;
  logic [5:0]        w_lzc;
  logic signed [6:0] w_k;
  logic signed [6:0] w_neg_k;
  logic [32:0]       w_sum;
  logic              w_shl_loss;
  logic [31:0]       w_mag;

  // |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude.
  assign w_abs_a = a[31] ? (~a + 32'd1) : a;
  assign w_abs_b = b[31] ? (~b + 32'd1) : b;

  shift_mul_lzc u_lzc (
    .i_data  (w_abs_a),
    .o_count (w_lzc)
  );

  // Weight of the current multiplier bit relative to the binary point.
  assign w_k     = $signed({2'b00, r_i}) - FracS;
  assign w_neg_k = -w_k;
  assign w_sum   = r_acc + {1'b0, sh_res};
  // A left shift by more than the leading-zero count drops set bits of |a|.
  assign w_shl_loss = !w_k[6] && (w_k[5:0] > r_lzc);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // Next state and shifter drive
  always_comb begin
    w_state_d = r_state;
    sh_in     = 32'd0;
    sh_op     = SH_SHL;
    sh_s      = 5'd0;
    unique case (r_state)
      IDLE: if (in_valid) w_state_d = RUN;
      RUN: begin
        sh_in = r_mag_a;
        if (w_k[6]) begin
          sh_op = SH_SHR;
          sh_s  = w_neg_k[4:0];
        end else begin
          sh_op = SH_SHL;
          sh_s  = w_k[4:0];
        end
        if (r_i == 5'd31) w_state_d = DONE;
      end
      DONE: if (out_ready) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a <= 32'd0;
      r_mag_b <= 32'd0;
      r_sign  <= 1'b0;
      r_lzc   <= 6'd0;
      r_acc   <= 33'd0;
      r_ovf   <= 1'b0;
      r_i     <= 5'd0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_mag_a <= w_abs_a;
        r_mag_b <= w_abs_b;
        r_sign  <= a[31] ^ b[31];
        r_lzc   <= w_lzc;
        r_acc   <= 33'd0;
        r_ovf   <= 1'b0;
        r_i     <= 5'd0;
      end else if (r_state == RUN) begin
        if (r_mag_b[r_i]) begin
          r_acc <= w_sum;
          if (w_shl_loss || (w_sum[32:31] != 2'b00)) r_ovf <= 1'b1;
        end
        r_i <= r_i + 5'd1;
      end
    end
  end

  // Result magnitude selection
  always_comb begin
`ifdef SHIFT_MUL_SAT_EN
    if (r_ovf) w_mag = r_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else       w_mag = r_acc[31:0];
`else
    w_mag = r_acc[31:0];
`endif
  end

  // Negating a zero magnitude yields zero, so no negative zero can appear.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = out_valid ? (r_sign ? (~w_mag + 32'd1) : w_mag) : 32'd0;
  assign ovf       = out_valid ? r_ovf : 1'b0;

endmodule

// File: tb/tb_shift_mul_seq.sv
module tb_shift_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic [31:0] sh_in;
  logic [1:0]  sh_op;
  logic [4:0]  sh_s;
  logic [31:0] sh_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural barrel shifter standing in for the real one.
  always_comb begin
    case (sh_op)
      2'b00:   sh_res = sh_in << sh_s;
      2'b01:   sh_res = sh_in >> sh_s;
      2'b10:   sh_res = $signed(sh_in) >>> sh_s;
      default: sh_res = (sh_in >> sh_s) | (sh_in << (6'd32 - {1'b0, sh_s}));
    endcase
  end

  shift_mul_seq #(.FRAC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .sh_in     (sh_in),
    .sh_op     (sh_op),
    .sh_s      (sh_s),
    .sh_res    (sh_res)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts an operation: drives operands before an edge and returns after the accept edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
  endtask

  // Counts edges after the accept edge until out_valid; caller is at a negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    check("out_valid_after_release", {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    logic [31:0] held_res;
    logic        held_ovf;

    vecs[0]  = '{32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0}; // 1.5 * 2
    vecs[1]  = '{32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0}; // -1.5 * 2
    vecs[2]  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0}; // 0 * min
    vecs[3]  = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0}; // 1 * 1
    vecs[4]  = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000, 1'b0}; // -1 * -1
    vecs[5]  = '{32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0}; // 0.5 * 0.5
    vecs[6]  = '{32'h0000_0003, 32'h0000_8000, 32'h0000_0001, 1'b0}; // truncation
    vecs[7]  = '{32'hFFFF_FFFD, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0}; // truncation, negative
    vecs[8]  = '{32'hFFFF_0000, 32'h0000_4000, 32'hFFFF_C000, 1'b0}; // -1 * 0.25
`ifdef SHIFT_MUL_SAT_EN
    vecs[9]  = '{32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1}; // acc[31] overflow
    vecs[10] = '{32'h4000_0000, 32'h0004_0000, 32'h7FFF_FFFF, 1'b1}; // SHL loses bits
`else
    vecs[9]  = '{32'h7FFF_0000, 32'h0002_0000, 32'hFFFE_0000, 1'b1};
    vecs[10] = '{32'h4000_0000, 32'h0004_0000, 32'h0000_0000, 1'b1};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    #12;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_sh", {sh_in[31:7] | 25'd0, sh_op, sh_s} | {sh_in}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].va, vecs[i].vb);
      wait_done(lat);
      check($sformatf("latency_%0d", i), lat, 32'd32);
      check($sformatf("result_%0d", i), result, vecs[i].exp_res);
      check($sformatf("ovf_%0d", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
      release_out();
    end

    // Back-pressure: result held for 10 cycles with out_ready low
    start_op(32'h0001_8000, 32'h0002_0000);
    wait_done(lat);
    held_res = result;
    held_ovf = ovf;
    check("bp_result", held_res, 32'h0003_0000);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_stable", result, 32'h0003_0000);
      check("bp_ovf", {31'd0, ovf}, {31'd0, held_ovf});
    end
    release_out();

    // Reset in the middle of RUN at i=12
    start_op(32'h0001_8000, 32'h0002_0000);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_sh_s_i12", {27'd0, sh_s}, 32'd4); // k = 12 - 16 = -4 -> SHR 4
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_sh_in", sh_in, 32'd0);
    check("abort_sh_ctl", {25'd0, sh_op, sh_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int spurious = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (out_valid) spurious++;
      end
      check("abort_no_spurious", spurious, 32'd0);
    end
    start_op(32'h0001_0000, 32'h0001_0000);
    wait_done(lat);
    check("post_abort_result", result, 32'h0001_0000);
    release_out();

    // Shifter drive for b = 0x00010001
    @(negedge clk);
    check("idle_sh_in", sh_in, 32'd0);
    check("idle_sh_ctl", {25'd0, sh_op, sh_s}, 32'd0);
    start_op(32'h0001_8000, 32'h0001_0001);
    check("i0_sh_op", {30'd0, sh_op}, 32'd1);
    check("i0_sh_s", {27'd0, sh_s}, 32'd16);
    check("i0_sh_in", sh_in, 32'h0001_8000);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("i16_sh_op", {30'd0, sh_op}, 32'd0);
    check("i16_sh_s", {27'd0, sh_s}, 32'd0);
    wait_done(lat);
    check("done_sh_in", sh_in, 32'd0);
    check("done_sh_ctl", {25'd0, sh_op, sh_s}, 32'd0);
    // 1.5 * (1.0 + 2^-16) = 0x18000 + 1 (0x18000 >> 16 = 1)
    check("drive_result", result, 32'h0001_8001);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
